// File: rtl/pi_sample_controller.sv
// Monte Carlo pi sampling sequencer: clears the pixel memory in raster order,
// then writes accepted random points and counts total / inside-circle samples.
module pi_sample_controller #(
  parameter int COORD_W = 9,
  parameter int GRID    = 480,
  parameter int COUNT_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [COUNT_W-1:0] sample_limit,
  input  logic [COORD_W-1:0] rand_x,
  input  logic [COORD_W-1:0] rand_y,
  input  logic               rand_valid,
  output logic [COORD_W-1:0] chk_x,
  output logic [COORD_W-1:0] chk_y,
  input  logic               is_inside,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic               wr_data,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] total_count,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W-1:0] GRID_MAX   = COORD_W'(GRID - 1);
  localparam logic [COORD_W-1:0] COORD_ZERO = COORD_W'(0);
  localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ZERO = COUNT_W'(0);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [COORD_W-1:0] clr_x_r, clr_x_nxt_s, clr_y_r, clr_y_nxt_s;
  logic [COORD_W-1:0] cand_x_r, cand_x_nxt_s, cand_y_r, cand_y_nxt_s;
  logic               cand_v_r, cand_v_nxt_s;
  logic [COUNT_W-1:0] hit_r, hit_nxt_s, total_r, total_nxt_s;
  logic [COUNT_W-1:0] limit_q_r, limit_q_nxt_s;
  logic               wr_en_s, wr_data_s;
  logic [COORD_W-1:0] wr_x_s, wr_y_s;
  logic               in_range_s, capture_ok_s;
  logic [COUNT_W:0]   pending_s;

  // Samples already counted plus the one in flight decide both capture and run end.
  assign in_range_s   = (rand_x <= GRID_MAX) && (rand_y <= GRID_MAX);
  assign pending_s    = {1'b0, total_r} + {COUNT_ZERO, cand_v_r};
  assign capture_ok_s = rand_valid && !pause && in_range_s && (pending_s < {1'b0, limit_q_r});

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      clr_x_r   <= COORD_ZERO;
      clr_y_r   <= COORD_ZERO;
      cand_x_r  <= COORD_ZERO;
      cand_y_r  <= COORD_ZERO;
      cand_v_r  <= 1'b0;
      hit_r     <= COUNT_ZERO;
      total_r   <= COUNT_ZERO;
      limit_q_r <= COUNT_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      clr_x_r   <= clr_x_nxt_s;
      clr_y_r   <= clr_y_nxt_s;
      cand_x_r  <= cand_x_nxt_s;
      cand_y_r  <= cand_y_nxt_s;
      cand_v_r  <= cand_v_nxt_s;
      hit_r     <= hit_nxt_s;
      total_r   <= total_nxt_s;
      limit_q_r <= limit_q_nxt_s;
    end
  end

  // Next-state, datapath updates and write-port decode.
  always_comb begin
    state_nxt_s   = state_r;
    clr_x_nxt_s   = clr_x_r;
    clr_y_nxt_s   = clr_y_r;
    cand_x_nxt_s  = cand_x_r;
    cand_y_nxt_s  = cand_y_r;
    cand_v_nxt_s  = 1'b0;
    hit_nxt_s     = hit_r;
    total_nxt_s   = total_r;
    limit_q_nxt_s = limit_q_r;
    wr_en_s       = 1'b0;
    wr_data_s     = 1'b0;
    wr_x_s        = COORD_ZERO;
    wr_y_s        = COORD_ZERO;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s   = ST_CLEAR;
          limit_q_nxt_s = sample_limit;
          hit_nxt_s     = COUNT_ZERO;
          total_nxt_s   = COUNT_ZERO;
          clr_x_nxt_s   = COORD_ZERO;
          clr_y_nxt_s   = COORD_ZERO;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CLEAR: begin
        wr_en_s = 1'b1;
        wr_x_s  = clr_x_r;
        wr_y_s  = clr_y_r;
        if (clr_x_r == GRID_MAX) begin
          clr_x_nxt_s = COORD_ZERO;
          if (clr_y_r == GRID_MAX) begin
            clr_y_nxt_s = COORD_ZERO;
            state_nxt_s = ST_SAMPLE;
          end else begin
            clr_y_nxt_s = clr_y_r + COORD_ONE;
          end
        end else begin
          clr_x_nxt_s = clr_x_r + COORD_ONE;
        end
      end
      ST_SAMPLE: begin
        if (cand_v_r) begin
          wr_en_s     = 1'b1;
          wr_data_s   = 1'b1;
          wr_x_s      = cand_x_r;
          wr_y_s      = cand_y_r;
          total_nxt_s = total_r + COUNT_ONE;
          hit_nxt_s   = hit_r + COUNT_W'(is_inside);
        end else begin
          wr_en_s = 1'b0;
        end
        if (capture_ok_s) begin
          cand_v_nxt_s = 1'b1;
          cand_x_nxt_s = rand_x;
          cand_y_nxt_s = rand_y;
        end else begin
          cand_v_nxt_s = 1'b0;
        end
        // Capture is blocked once pending reaches the limit, so no candidate is lost here.
        if (pending_s >= {1'b0, limit_q_r}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SAMPLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign chk_x       = cand_x_r;
  assign chk_y       = cand_y_r;
  assign wr_en       = wr_en_s;
  assign wr_x        = wr_x_s;
  assign wr_y        = wr_y_s;
  assign wr_data     = wr_data_s;
  assign hit_count   = hit_r;
  assign total_count = total_r;
  assign busy        = (state_r == ST_CLEAR) || (state_r == ST_SAMPLE);
  assign done        = (state_r == ST_DONE);

endmodule

// File: tb/tb_pi_sample_controller.sv
// Bench for pi_sample_controller (GRID=4): behavioural run model plus a
// hand-derived vector table for the limit-3 sampling sequence.
module tb_pi_sample_controller;

  localparam int CW = 3;
  localparam int G  = 4;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, pause, rand_valid, is_inside;
  logic [NW-1:0] sample_limit;
  logic [CW-1:0] rand_x, rand_y, chk_x, chk_y, wr_x, wr_y;
  logic          wr_en, wr_data, busy, done;
  logic [NW-1:0] hit_count, total_count;
  logic [63:0]   inside_tbl;

  pi_sample_controller #(.COORD_W(CW), .GRID(G), .COUNT_W(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .sample_limit(sample_limit), .rand_x(rand_x), .rand_y(rand_y),
    .rand_valid(rand_valid), .chk_x(chk_x), .chk_y(chk_y),
    .is_inside(is_inside), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .hit_count(hit_count), .total_count(total_count),
    .busy(busy), .done(done)
  );

  // The circle checker is stood in for by a lookup table indexed by the candidate.
  assign is_inside = inside_tbl[{chk_y, chk_x}];

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run model: phase 0 idle, 1 clearing, 2 sampling, 3 finished.
  int         m_phase, m_idx, m_total, m_hit, m_limit, m_acc;
  bit         m_pend;
  logic [2:0] m_px, m_py;

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_total = 0; m_hit = 0; m_limit = 0; m_acc = 0;
    m_pend = 1'b0; m_px = 3'd0; m_py = 3'd0;
  endtask

  task automatic check_model();
    int ew, ex, ey, ed;
    ew = 0; ex = 0; ey = 0; ed = 0;
    if (m_phase == 1) begin
      ew = 1; ex = m_idx % G; ey = m_idx / G;
    end else if (m_phase == 2 && m_pend) begin
      ew = 1; ed = 1; ex = int'(m_px); ey = int'(m_py);
    end
    check("wr_en", 32'(wr_en), ew);
    check("wr_x", 32'(wr_x), ex);
    check("wr_y", 32'(wr_y), ey);
    check("wr_data", 32'(wr_data), ed);
    check("busy", 32'(busy), (m_phase == 1 || m_phase == 2) ? 1 : 0);
    check("done", 32'(done), (m_phase == 3) ? 1 : 0);
    check("total", 32'(total_count), m_total);
    check("hit", 32'(hit_count), m_hit);
    if (m_pend) begin
      check("chk_x", 32'(chk_x), int'(m_px));
      check("chk_y", 32'(chk_y), int'(m_py));
    end
  endtask

  task automatic model_edge(input logic st, input logic ps, input logic rv,
                            input logic [CW-1:0] rx, input logic [CW-1:0] ry,
                            input logic [NW-1:0] lim);
    case (m_phase)
      0, 3: begin
        if (st) begin
          m_phase = 1; m_idx = 0; m_total = 0; m_hit = 0; m_acc = 0;
          m_limit = int'(lim); m_pend = 1'b0;
        end
      end
      1: begin
        m_idx++;
        if (m_idx == G * G) m_phase = 2;
      end
      default: begin
        if (m_pend) begin
          m_total++;
          m_hit += int'(inside_tbl[{m_py, m_px}]);
        end
        m_pend = 1'b0;
        if (rv && !ps && int'(rx) < G && int'(ry) < G && m_acc < m_limit) begin
          m_pend = 1'b1; m_acc++; m_px = rx; m_py = ry;
        end
        if (m_total == m_limit) m_phase = 3;
      end
    endcase
  endtask

  // One clock: check the current cycle, drive the inputs for the next edge.
  task automatic tick(input logic st, input logic ps, input logic rv,
                      input logic [CW-1:0] rx, input logic [CW-1:0] ry,
                      input logic [NW-1:0] lim);
    check_model();
    start = st; pause = ps; rand_valid = rv; rand_x = rx; rand_y = ry;
    sample_limit = lim;
    model_edge(st, ps, rv, rx, ry, lim);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0);
  endtask

  task automatic rand_tick(input logic st_en, input logic [NW-1:0] lim);
    logic st, ps, rv;
    logic [CW-1:0] rx, ry;
    st = st_en && ($urandom_range(0, 19) == 0);
    ps = ($urandom_range(0, 9) < 2);
    rv = ($urandom_range(0, 9) < 7);
    rx = CW'($urandom_range(0, 5));
    ry = CW'($urandom_range(0, 5));
    tick(st, ps, rv, rx, ry, lim);
  endtask

  // Async reset mid-cycle: outputs must clear before the next clock edge.
  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_total"}, 32'(total_count), 0);
    check({tag, "_hit"}, 32'(hit_count), 0);
    check({tag, "_wr_x"}, 32'(wr_x), 0);
    check({tag, "_chk_x"}, 32'(chk_x), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b0; pause = 1'b0; rand_valid = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  typedef struct {
    logic          rv;
    logic [CW-1:0] x, y;
    logic          e_wr;
    logic [CW-1:0] e_x, e_y;
    logic          e_data;
    int            e_tot, e_hit;
    logic          e_busy, e_done;
  } vec_t;

  vec_t vecs[7];
  int   n;
  int   tot_before;

  initial begin
    vecs[0] = '{1'b1, 3'd1, 3'd1, 1'b0, 3'd0, 3'd0, 1'b0, 0, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 3'd5, 3'd0, 1'b1, 3'd1, 3'd1, 1'b1, 0, 0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0, 1, 1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 3'd0, 1'b1, 3'd2, 3'd3, 1'b1, 1, 1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 3'd0, 1'b1, 2, 1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 3, 2, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0, 3, 2, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; pause = 1'b0; rand_valid = 1'b0;
    rand_x = 3'd0; rand_y = 3'd0; sample_limit = 8'd0; inside_tbl = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_total", 32'(total_count), 0);
    check("rst_hit", 32'(hit_count), 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset after five clear writes, then a fresh clear sweep from (0,0).
    tick(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd5);
    repeat (5) idle_tick();
    async_reset_check("clr_rst");

    // Limit 3 with the hand-derived sequence.
    inside_tbl[{3'd1, 3'd1}] = 1'b1;
    inside_tbl[{3'd0, 3'd0}] = 1'b1;
    inside_tbl[{3'd3, 3'd3}] = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd3);
    repeat (G * G) idle_tick();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("vec%0d_wr_en", i), 32'(wr_en), int'(vecs[i].e_wr));
      check($sformatf("vec%0d_wr_x", i), 32'(wr_x), int'(vecs[i].e_x));
      check($sformatf("vec%0d_wr_y", i), 32'(wr_y), int'(vecs[i].e_y));
      check($sformatf("vec%0d_wr_data", i), 32'(wr_data), int'(vecs[i].e_data));
      check($sformatf("vec%0d_total", i), 32'(total_count), vecs[i].e_tot);
      check($sformatf("vec%0d_hit", i), 32'(hit_count), vecs[i].e_hit);
      check($sformatf("vec%0d_busy", i), 32'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), 32'(done), int'(vecs[i].e_done));
      tick(1'b0, 1'b0, vecs[i].rv, vecs[i].x, vecs[i].y, 8'd3);
    end
    async_reset_check("done_rst");

    // Random run with a pause window and a single-cycle release check.
    inside_tbl = {$urandom, $urandom};
    tick(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd12);
    repeat (G * G) rand_tick(1'b0, 8'd12);
    tot_before = m_total + (m_pend ? 1 : 0);
    for (int i = 0; i < 10; i++)
      tick(1'b0, 1'b1, 1'b1, CW'(i % G), CW'((i + 1) % G), 8'd12);
    check("pause_frozen_total", 32'(total_count), tot_before);
    check("pause_no_write", 32'(wr_en), 0);
    tick(1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 8'd12);
    check("release_wr_en", 32'(wr_en), 1);
    check("release_wr_x", 32'(wr_x), 1);
    check("release_wr_y", 32'(wr_y), 2);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      rand_tick(1'b1, 8'd12);
      n++;
    end
    check("run12_finished", 32'(done), 1);
    check("run12_total", 32'(total_count), 12);

    // Restart from DONE with limit 0: clear sweep then straight to done.
    tick(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd0);
    repeat (G * G) rand_tick(1'b0, 8'd0);
    rand_tick(1'b0, 8'd0);
    check("lim0_done", 32'(done), 1);
    check("lim0_total", 32'(total_count), 0);
    check("lim0_hit", 32'(hit_count), 0);
    idle_tick();

    // Another restart with a small limit, random starts ignored mid-run.
    tick(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'd4);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      rand_tick(1'b1, 8'd9);
      n++;
    end
    check("run4_finished", 32'(done), 1);
    check("run4_total", 32'(total_count), 4);
    idle_tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
